spike_pkt_collector: RTL and testbench

SPIKE_PKT_COLLECTOR -- requirements
Module: spike_pkt_collector

---
 rtl/spike_pkt_collector.sv | 176 +++++++++++++++++
 tb/tb_spike_pkt_collector.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/spike_pkt_collector.sv
// spike_pkt_collector
// Collects incoming axon-addressed spike packets through a small FIFO into a
// per-step accumulator vector. A step request closes the current step: the
// FIFO is drained, the accumulated vector is published on spike_o and start_o
// pulses for one cycle.
// Optional feature: define SPIKE_CNT_EN to add cnt_o, the number of distinct
// axons that spiked in the last completed step.
module spike_pkt_collector #(
   parameter int NUM_AXONS          = 256,
   parameter int AXON_CNT_BIT_WIDTH = 8,
   parameter int FIFO_DEPTH         = 4
) (
   input  logic                          clk_i,
   input  logic                          rst_n_i,
   input  logic                          pkt_valid_i,
   input  logic [AXON_CNT_BIT_WIDTH-1:0] pkt_axon_i,
   output logic                          pkt_ready_o,
   input  logic                          step_i,
   output logic [NUM_AXONS-1:0]          spike_o,
   output logic                          start_o,
   output logic                          drop_o,
   output logic                          ovr_o
`ifdef SPIKE_CNT_EN
   ,
   output logic [AXON_CNT_BIT_WIDTH:0]   cnt_o
`endif
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [PTR_W:0]              DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);
   localparam logic [AXON_CNT_BIT_WIDTH:0] NUM_C   = (AXON_CNT_BIT_WIDTH+1)'(NUM_AXONS);

   typedef enum logic {COLLECT = 1'b0, DRAIN = 1'b1} state_t;

   state_t                          state_q, state_d;
   logic [AXON_CNT_BIT_WIDTH-1:0]   mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]                wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]                rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]                  fill_q, fill_d;
   logic [NUM_AXONS-1:0]            acc_q, acc_d;
   logic [NUM_AXONS-1:0]            spike_q, spike_d;
   logic                            start_q, start_d;
   logic                            drop_q, drop_d;
   logic                            ovr_q, ovr_d;

   logic                            fifo_empty;
   logic                            fifo_full;
   logic                            push;
   logic                            pop;
   logic                            pop_in_range;
   logic [AXON_CNT_BIT_WIDTH-1:0]   pop_addr;
   logic                            load_spike;

   assign fifo_empty   = (fill_q == '0);
   assign fifo_full    = (fill_q == DEPTH_C);
   assign pkt_ready_o  = (state_q == COLLECT) && !fifo_full;
   assign push         = pkt_valid_i && pkt_ready_o;
   assign pop          = !fifo_empty;
   assign pop_addr     = mem_q[rd_ptr_q];
   assign pop_in_range = pop && ({1'b0, pop_addr} < NUM_C);
   // The publishing edge: DRAIN with nothing left to merge.
   assign load_spike   = (state_q == DRAIN) && fifo_empty;

   assign spike_o = spike_q;
   assign start_o = start_q;
   assign drop_o  = drop_q;
   assign ovr_o   = ovr_q;

   // Next-state logic: FIFO pointers, accumulator merge, step FSM and flags.
   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      fill_d   = fill_q;
      acc_d    = acc_q;
      spike_d  = spike_q;
      start_d  = 1'b0;
      drop_d   = drop_q;
      ovr_d    = ovr_q;

      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
         2'b10:   fill_d = fill_q + (PTR_W+1)'(1);
         2'b01:   fill_d = fill_q - (PTR_W+1)'(1);
         default: fill_d = fill_q;
      endcase

      // Decoded set of the popped address; duplicates simply OR in again.
      for (int i = 0; i < NUM_AXONS; i++) begin
         if (pop_in_range && (pop_addr == AXON_CNT_BIT_WIDTH'(i))) acc_d[i] = 1'b1;
      end
      if (pop && !pop_in_range) drop_d = 1'b1;

      case (state_q)
         COLLECT: begin
            if (step_i) state_d = DRAIN;
         end
         DRAIN: begin
            if (step_i) ovr_d = 1'b1;
            if (fifo_empty) begin
               spike_d = acc_q;
               acc_d   = '0;
               start_d = 1'b1;
               state_d = COLLECT;
            end
         end
         default: state_d = COLLECT;
      endcase
   end

   // Control and vector state; reset discards any queued packets and open step.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q  <= COLLECT;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         fill_q   <= '0;
         acc_q    <= '0;
         spike_q  <= '0;
         start_q  <= 1'b0;
         drop_q   <= 1'b0;
         ovr_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         fill_q   <= fill_d;
         acc_q    <= acc_d;
         spike_q  <= spike_d;
         start_q  <= start_d;
         drop_q   <= drop_d;
         ovr_q    <= ovr_d;
      end
   end

   // FIFO storage; contents are meaningless while the fill count is zero.
   always_ff @(posedge clk_i) begin
      if (push) mem_q[wr_ptr_q] <= pkt_axon_i;
   end

`ifdef SPIKE_CNT_EN
   logic [AXON_CNT_BIT_WIDTH:0] cnt_acc_q, cnt_acc_d;
   logic [AXON_CNT_BIT_WIDTH:0] cnt_q, cnt_d;
   logic                        was_set;

   assign cnt_o = cnt_q;

   // Count only first-time sets of an accumulator bit; publish with spike_o.
   always_comb begin
      cnt_acc_d = cnt_acc_q;
      cnt_d     = cnt_q;
      was_set   = 1'b0;
      for (int i = 0; i < NUM_AXONS; i++) begin
         if (pop_addr == AXON_CNT_BIT_WIDTH'(i)) was_set = was_set | acc_q[i];
      end
      if (pop_in_range && !was_set) cnt_acc_d = cnt_acc_q + (AXON_CNT_BIT_WIDTH+1)'(1);
      if (load_spike) begin
         cnt_d     = cnt_acc_q;
         cnt_acc_d = '0;
      end
   end

   // Counter registers.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cnt_acc_q <= '0;
         cnt_q     <= '0;
      end else begin
         cnt_acc_q <= cnt_acc_d;
         cnt_q     <= cnt_d;
      end
   end
`endif

endmodule

// File: tb/tb_spike_pkt_collector.sv
// Directed, table-driven bench for spike_pkt_collector (NUM_AXONS=256,
// 9-bit axon address so out-of-range addresses can be driven, FIFO_DEPTH=4).
module tb_spike_pkt_collector;

   localparam int NA = 256;
   localparam int AW = 9;
   localparam int FD = 4;

   logic          clk_i = 1'b0;
   logic          rst_n_i;
   logic          pkt_valid_i;
   logic [AW-1:0] pkt_axon_i;
   logic          pkt_ready_o;
   logic          step_i;
   logic [NA-1:0] spike_o;
   logic          start_o;
   logic          drop_o;
   logic          ovr_o;
`ifdef SPIKE_CNT_EN
   logic [AW:0]   cnt_o;
`endif

   spike_pkt_collector #(
      .NUM_AXONS(NA), .AXON_CNT_BIT_WIDTH(AW), .FIFO_DEPTH(FD)
   ) dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i),
      .pkt_valid_i(pkt_valid_i), .pkt_axon_i(pkt_axon_i), .pkt_ready_o(pkt_ready_o),
      .step_i(step_i), .spike_o(spike_o), .start_o(start_o),
      .drop_o(drop_o), .ovr_o(ovr_o)
`ifdef SPIKE_CNT_EN
      , .cnt_o(cnt_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic          v;
      int            a;
      logic          s;
      logic          rdy;
      logic          st;
      logic          dr;
      logic          ov;
      logic [NA-1:0] spk;
      int            cnt;
   } vec_t;

   vec_t tbl[$];
   int   checks = 0;
   int   errors = 0;

   function automatic logic [NA-1:0] bits(input int a, input int b, input int c, input int d);
      logic [NA-1:0] r;
      r = '0;
      for (int i = 0; i < NA; i++)
         if (i == a || i == b || i == c || i == d) r[i] = 1'b1;
      return r;
   endfunction

   task automatic add(input logic v, input int a, input logic s, input logic rdy,
                      input logic st, input logic dr, input logic ov,
                      input logic [NA-1:0] spk, input int cnt);
      vec_t r;
      r.v = v; r.a = a; r.s = s; r.rdy = rdy; r.st = st; r.dr = dr; r.ov = ov;
      r.spk = spk; r.cnt = cnt;
      tbl.push_back(r);
   endtask

   task automatic chk(input string name, input logic [NA-1:0] act, input logic [NA-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk_all(input string tag, input logic rdy, input logic st, input logic dr,
                          input logic ov, input logic [NA-1:0] spk, input int cnt);
      chk({tag, " ready"}, NA'(pkt_ready_o), NA'(rdy));
      chk({tag, " start"}, NA'(start_o), NA'(st));
      chk({tag, " drop"},  NA'(drop_o), NA'(dr));
      chk({tag, " ovr"},   NA'(ovr_o), NA'(ov));
      chk({tag, " spike"}, spike_o, spk);
`ifdef SPIKE_CNT_EN
      chk({tag, " cnt"},   NA'(cnt_o), NA'(cnt));
`else
      if (cnt < 0) $display("negative count %0d", cnt);
`endif
   endtask

   initial begin
      logic [NA-1:0] s37, s9, s20, s5;
      s37 = bits(3, 7, -1, -1);
      s9  = bits(9, -1, -1, -1);
      s20 = bits(20, 21, 22, 23);
      s5  = bits(5, -1, -1, -1);

      // v  a   s | rdy st dr ov spike cnt
      // packets 3,7,3 then a step
      add(1, 3,   0, 1, 0, 0, 0, '0,  0);
      add(1, 7,   0, 1, 0, 0, 0, '0,  0);
      add(1, 3,   0, 1, 0, 0, 0, '0,  0);
      add(0, 0,   1, 0, 0, 0, 0, '0,  0);
      add(0, 0,   0, 1, 1, 0, 0, s37, 2);
      add(0, 0,   0, 1, 0, 0, 0, s37, 2);
      // empty step: start on the second edge, all-zero vector
      add(0, 0,   1, 0, 0, 0, 0, s37, 2);
      add(0, 0,   0, 1, 1, 0, 0, '0,  0);
      add(0, 0,   0, 1, 0, 0, 0, '0,  0);
      // packet 9 on the same edge as the step
      add(1, 9,   1, 0, 0, 0, 0, '0,  0);
      add(0, 0,   0, 0, 0, 0, 0, '0,  0);
      add(0, 0,   0, 1, 1, 0, 0, s9,  1);
      add(0, 0,   1, 0, 0, 0, 0, s9,  1);
      add(0, 0,   0, 1, 1, 0, 0, '0,  0);
      add(0, 0,   0, 1, 0, 0, 0, '0,  0);
      // valid held across the step; packet 24 must be refused in DRAIN
      add(1, 20,  0, 1, 0, 0, 0, '0,  0);
      add(1, 21,  0, 1, 0, 0, 0, '0,  0);
      add(1, 22,  0, 1, 0, 0, 0, '0,  0);
      add(1, 23,  1, 0, 0, 0, 0, '0,  0);
      add(1, 24,  0, 0, 0, 0, 0, '0,  0);
      add(1, 24,  0, 1, 1, 0, 0, s20, 4);
      add(0, 0,   0, 1, 0, 0, 0, s20, 4);
      // out-of-range address, then a step requested again during DRAIN
      add(1, 5,   0, 1, 0, 0, 0, s20, 4);
      add(1, 300, 0, 1, 0, 0, 0, s20, 4);
      add(0, 0,   0, 1, 0, 1, 0, s20, 4);
      add(0, 0,   1, 0, 0, 1, 0, s20, 4);
      add(0, 0,   1, 1, 1, 1, 1, s5,  1);
      add(0, 0,   0, 1, 0, 1, 1, s5,  1);

      rst_n_i = 1'b0; pkt_valid_i = 1'b0; pkt_axon_i = '0; step_i = 1'b0;
      tick(); tick();
      chk_all("reset", 1, 0, 0, 0, '0, 0);
      rst_n_i = 1'b1;
      tick();
      chk_all("idle", 1, 0, 0, 0, '0, 0);

      for (int i = 0; i < tbl.size(); i++) begin
         pkt_valid_i = tbl[i].v;
         pkt_axon_i  = AW'(tbl[i].a);
         step_i      = tbl[i].s;
         tick();
         chk_all($sformatf("row%0d", i + 1), tbl[i].rdy, tbl[i].st, tbl[i].dr,
                 tbl[i].ov, tbl[i].spk, tbl[i].cnt);
      end
      pkt_valid_i = 1'b0; step_i = 1'b0;

      // Reset in the middle of DRAIN with a packet still queued.
      pkt_valid_i = 1'b1; pkt_axon_i = AW'(40);
      tick();
      pkt_axon_i = AW'(41); step_i = 1'b1;
      tick();
      pkt_valid_i = 1'b0; step_i = 1'b0;
      chk_all("pre_rst_drain", 0, 0, 1, 1, s5, 1);
      rst_n_i = 1'b0;
      #2;
      chk_all("async_rst", 1, 0, 0, 0, '0, 0);
      tick();
      rst_n_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk_all($sformatf("post_rst%0d", i), 1, 0, 0, 0, '0, 0);
      end
      step_i = 1'b1;
      tick();
      step_i = 1'b0;
      tick();
      chk_all("post_rst_step", 1, 1, 0, 0, '0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
